// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widest operand the helper below can handle.
    localparam int MAX_W = 64;

    // Returns the two's-complement negation of val when neg is set, else val.
    // Callers zero-extend a WIDTH-bit operand and keep the low WIDTH bits of
    // the result. This gives |x| for a negative signed x, and also the
    // sign-corrected quotient and remainder. The most negative value maps
    // onto itself, which reads correctly as an unsigned magnitude.
    function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] val,
                                                  input logic             neg);
        return neg ? (~val + 1'b1) : val;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {prem, quo} left, trial-subtract
// the divisor magnitude, and keep the difference when it does not underflow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] prem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Trial subtraction, with one guard bit so that its MSB is a clean borrow.
    always_comb begin
        shifted = {prem, quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dmag};
        if (trial[WIDTH+1]) begin
            prem_nxt = shifted[WIDTH-1:0];
            quo_nxt  = {quo[WIDTH-2:0], 1'b0};
        end else begin
            // The remainder stays below dmag, so it fits in WIDTH bits.
            prem_nxt = WIDTH'(trial);
            quo_nxt  = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider with per-operation signed mode,
// divide-by-zero detection and a start/done handshake.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] rem,
    output logic             done,
    output logic             busy,
    output logic             dbz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_step;

    // Operands are captured at the accepting edge so that callers may change them afterwards.
    logic [WIDTH-1:0] num_raw;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] quo;
    logic             q_neg;
    logic             r_neg;
    logic             dbz_pend;

    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign accept    = (state == IDLE) && start;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem     (prem),
        .quo      (quo),
        .dmag     (dmag),
        .prem_nxt (prem_nxt),
        .quo_nxt  (quo_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. A zero divisor skips CALC and goes straight to FIX,
    // so done rises one edge after acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (den == '0) ? FIX : CALC;
            CALC: if (last_step) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Iteration counter: cleared on acceptance, advanced once per CALC edge.
    always_ff @(posedge clk) begin
        if (rst)                cnt <= '0;
        else if (accept)        cnt <= '0;
        else if (state == CALC) cnt <= cnt + 1'b1;
    end

    // Operand capture and restoring iterations. A reset only needs to stop
    // the controller, so these registers are not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            num_raw  <= num;
            dbz_pend <= (den == '0);
            q_neg    <= sgn & (num[WIDTH-1] ^ den[WIDTH-1]);
            r_neg    <= sgn & num[WIDTH-1];
            quo      <= WIDTH'(twos_mag(MAX_W'(num), sgn & num[WIDTH-1]));
            dmag     <= WIDTH'(twos_mag(MAX_W'(den), sgn & den[WIDTH-1]));
            prem     <= '0;
        end else if (state == CALC) begin
            prem <= prem_nxt;
            quo  <= quo_nxt;
        end
    end

    // Result registers: updated only in FIX and held until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            rem <= '0;
            dbz <= 1'b0;
        end else if (state == FIX) begin
            if (dbz_pend) begin
                res <= '1;
                rem <= num_raw;
                dbz <= 1'b1;
            end else begin
                // For most-negative / -1 the quotient wraps back onto itself.
                res <= WIDTH'(twos_mag(MAX_W'(quo), q_neg));
                rem <= WIDTH'(twos_mag(MAX_W'(prem), r_neg));
                dbz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_seq_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, sgn8, done8, busy8, dbz8;
    logic [7:0]  num8, den8, res8, rem8;
    logic        start16, sgn16, done16, busy16, dbz16;
    logic [15:0] num16, den16, res16, rem16;

    int tests = 0;
    int fails = 0;

    seq_div #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .num(num8), .den(den8),
        .res(res8), .rem(rem8), .done(done8), .busy(busy8), .dbz(dbz8)
    );

    seq_div #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .num(num16), .den(den16),
        .res(res16), .rem(rem16), .done(done16), .busy(busy16), .dbz(dbz16)
    );

    // Reference: plain integer division; signed operands are sign-extended,
    // and SV '/' and '%' truncate toward zero with the remainder following the dividend.
    task automatic ref_div(input int w, input logic s, input logic [31:0] n, input logic [31:0] d,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        longint a, b, mask;
        mask = (longint'(1) << w) - 1;
        if (d == 32'd0) begin
            q = 32'(mask);
            r = n;
            z = 1'b1;
        end else begin
            a = longint'(n);
            b = longint'(d);
            if (s && n[w-1]) a = a - (longint'(1) << w);
            if (s && d[w-1]) b = b - (longint'(1) << w);
            q = 32'((a / b) & mask);
            r = 32'((a % b) & mask);
            z = 1'b0;
        end
    endtask

    // One 8-bit operation; lat counts edges from acceptance to the first done sample.
    task automatic run8(input logic s, input logic [7:0] n, input logic [7:0] d,
                        output logic [7:0] q, output logic [7:0] r, output logic z, output int lat);
        @(negedge clk);
        sgn8 = s; num8 = n; den8 = d; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        sgn8 = 1'($urandom); num8 = 8'($urandom); den8 = 8'($urandom);
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = res8; r = rem8; z = dbz8;
        @(posedge clk); #1;
    endtask

    task automatic run16(input logic s, input logic [15:0] n, input logic [15:0] d,
                         output logic [15:0] q, output logic [15:0] r, output logic z, output int lat);
        @(negedge clk);
        sgn16 = s; num16 = n; den16 = d; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        sgn16 = 1'($urandom); num16 = 16'($urandom); den16 = 16'($urandom);
        lat = 0;
        while (done16 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        q = res16; r = rem16; z = dbz16;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 0; sgn8 = 0; num8 = 0; den8 = 0;
        start16 = 0; sgn16 = 0; num16 = 0; den16 = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({res8, rem8, done8, busy8, dbz8} !== 19'd0) begin
            fails++;
            $display("FAIL reset8: got res=%h rem=%h done=%b busy=%b dbz=%b, expected all zero",
                     res8, rem8, done8, busy8, dbz8);
        end
        tests++;
        if ({res16, rem16, done16, busy16, dbz16} !== 35'd0) begin
            fails++;
            $display("FAIL reset16: got res=%h rem=%h done=%b busy=%b dbz=%b, expected all zero",
                     res16, rem16, done16, busy16, dbz16);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [7:0] q, r; logic z; int lat;
        run8(1'b0, 8'd17, 8'd5, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'd3, 8'd2, 1'b0}) begin
            fails++;
            $display("FAIL unsigned_17_5: got res=%0d rem=%0d dbz=%b, expected 3 2 0", q, r, z);
        end
        tests++;
        if (lat !== 9) begin
            fails++;
            $display("FAIL latency8: got %0d edges, expected 9", lat);
        end
        tests++;
        if ({done8, busy8} !== 2'b00) begin
            fails++;
            $display("FAIL done_pulse: got done=%b busy=%b one cycle later, expected 0 0", done8, busy8);
        end
    endtask

    task automatic test_signed();
        logic [7:0] q, r; logic z; int lat;
        run8(1'b1, 8'hEF, 8'd5, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'hFD, 8'hFE, 1'b0}) begin
            fails++;
            $display("FAIL signed_m17_5: got res=%h rem=%h dbz=%b, expected fd fe 0", q, r, z);
        end
        run8(1'b1, 8'd17, 8'hFB, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'hFD, 8'h02, 1'b0}) begin
            fails++;
            $display("FAIL signed_17_m5: got res=%h rem=%h dbz=%b, expected fd 02 0", q, r, z);
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic z; int lat;
        run8(1'b0, 8'd17, 8'd0, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'hFF, 8'd17, 1'b1}) begin
            fails++;
            $display("FAIL dbz_17_0: got res=%h rem=%0d dbz=%b, expected ff 17 1", q, r, z);
        end
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL dbz_latency: got %0d edges, expected 1", lat);
        end
        tests++;
        if (dbz8 !== 1'b1) begin
            fails++;
            $display("FAIL dbz_hold: got dbz=%b after done, expected 1", dbz8);
        end
        run8(1'b0, 8'd20, 8'd4, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'd5, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL after_dbz_20_4: got res=%0d rem=%0d dbz=%b, expected 5 0 0", q, r, z);
        end
        run8(1'b1, 8'h91, 8'd0, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'hFF, 8'h91, 1'b1}) begin
            fails++;
            $display("FAIL dbz_signed_raw: got res=%h rem=%h dbz=%b, expected ff 91 1", q, r, z);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q, r; logic z; int lat;
        run8(1'b1, 8'h80, 8'hFF, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'h80, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL signed_overflow: got res=%h rem=%h dbz=%b, expected 80 00 0", q, r, z);
        end
        run8(1'b0, 8'h80, 8'hFF, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {8'h00, 8'h80, 1'b0}) begin
            fails++;
            $display("FAIL unsigned_80_ff: got res=%h rem=%h dbz=%b, expected 00 80 0", q, r, z);
        end
    endtask

    task automatic test_overlap();
        int dones;
        logic [7:0] q_seen, r_seen;
        dones = 0; q_seen = 8'd0; r_seen = 8'd0;
        @(negedge clk);
        sgn8 = 1'b0; num8 = 8'd100; den8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b1; num8 = 8'd9; den8 = 8'd3;
        for (int i = 2; i <= 24; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                dones++;
                q_seen = res8;
                r_seen = rem8;
            end
            if (i == 10) start8 = 1'b0;
        end
        tests++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL overlap_done_count: got %0d done pulses, expected 1", dones);
        end
        tests++;
        if ({q_seen, r_seen, res8} !== {8'd14, 8'd2, 8'd14}) begin
            fails++;
            $display("FAIL overlap_result: got res=%0d rem=%0d final=%0d, expected 14 2 14",
                     q_seen, r_seen, res8);
        end
    endtask

    task automatic test_abort();
        logic [7:0] q, r; logic z; int lat; int dones;
        run8(1'b0, 8'd33, 8'd0, q, r, z, lat);
        @(negedge clk);
        sgn8 = 1'b0; num8 = 8'd200; den8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({res8, rem8, dbz8, busy8, done8} !== 19'd0) begin
            fails++;
            $display("FAIL abort_reset: got res=%h rem=%h dbz=%b busy=%b done=%b, expected all zero",
                     res8, rem8, dbz8, busy8, done8);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones);
        end
    endtask

    task automatic test_random();
        logic [7:0] q, r, n, d; logic z, s; int lat;
        logic [31:0] eq, er; logic ez;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            n = 8'($urandom);
            d = (i % 8 == 7) ? 8'd0 : 8'($urandom);
            run8(s, n, d, q, r, z, lat);
            ref_div(8, s, {24'd0, n}, {24'd0, d}, eq, er, ez);
            tests++;
            if ({24'd0, q} !== eq || {24'd0, r} !== er || z !== ez || lat !== (ez ? 1 : 9)) begin
                fails++;
                $display("FAIL random8 s=%b %h/%h: got res=%h rem=%h dbz=%b lat=%0d, expected %h %h %b %0d",
                         s, n, d, q, r, z, lat, eq, er, ez, ez ? 1 : 9);
            end
        end
    endtask

    task automatic test_wide();
        logic [15:0] q, r, n, d; logic z, s; int lat;
        logic [31:0] eq, er; logic ez;
        run16(1'b0, 16'd65535, 16'd255, q, r, z, lat);
        tests++;
        if ({q, r, z} !== {16'd257, 16'd0, 1'b0} || lat !== 17) begin
            fails++;
            $display("FAIL wide_65535_255: got res=%0d rem=%0d dbz=%b lat=%0d, expected 257 0 0 17",
                     q, r, z, lat);
        end
        for (int i = 0; i < 12; i++) begin
            s = 1'($urandom);
            n = 16'($urandom);
            d = (i == 5) ? 16'd0 : 16'($urandom_range(1, 700));
            if (i % 2 == 1) d = -d;
            run16(s, n, d, q, r, z, lat);
            ref_div(16, s, {16'd0, n}, {16'd0, d}, eq, er, ez);
            tests++;
            if ({16'd0, q} !== eq || {16'd0, r} !== er || z !== ez || lat !== (ez ? 1 : 17)) begin
                fails++;
                $display("FAIL random16 s=%b %h/%h: got res=%h rem=%h dbz=%b lat=%0d, expected %h %h %b %0d",
                         s, n, d, q, r, z, lat, eq, er, ez, ez ? 1 : 17);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_overlap();
        test_abort();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
